// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC stage: next-PC select encodings, FSM states,
// reset/exception addresses and the branch-offset helper.
package pc_sequencer_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NPC_SEL_W = 3;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned JIDX_W    = 26;

    localparam logic [NPC_SEL_W-1:0] NPC_SEL_SEQ    = 3'd0;
    localparam logic [NPC_SEL_W-1:0] NPC_SEL_BRANCH = 3'd1;
    localparam logic [NPC_SEL_W-1:0] NPC_SEL_JUMP   = 3'd2;
    localparam logic [NPC_SEL_W-1:0] NPC_SEL_JR     = 3'd3;
    localparam logic [NPC_SEL_W-1:0] NPC_SEL_ERET   = 3'd4;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h0040_0004;
    localparam logic [XLEN-1:0] PC_STEP_DEF  = 32'd4;

    typedef enum logic [1:0] {
        PC_IDLE = 2'd0,
        PC_INC  = 2'd1,
        PC_WAIT = 2'd2
    } pc_state_e;

    // Signed word offset turned into a byte offset.
    function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter stage of the multi-cycle core: holds PC/EPC, borrows the
// datapath's shared adder for PC+4 and branch targets, commits on pc_we.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] EXC_VEC  = EXC_VEC_DEF,
    parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_done_i,
    input  logic                 pc_we_i,
    input  logic [NPC_SEL_W-1:0] npc_sel_i,
    input  logic                 branch_taken_i,
    input  logic [IMM_W-1:0]     imm16_i,
    input  logic [JIDX_W-1:0]    jidx_i,
    input  logic [XLEN-1:0]      rs_val_i,
    input  logic                 exc_req_i,
    input  logic [XLEN-1:0]      adder_r_i,
    output logic [XLEN-1:0]      adder_a_o,
    output logic [XLEN-1:0]      adder_b_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [XLEN-1:0]      pc_plus4_o,
    output logic [XLEN-1:0]      epc_o,
    output logic                 npc_ready_o
);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic [XLEN-1:0] epc_q;
    logic            npc_ready_q;
    logic [XLEN-1:0] target_d;

    // Adder operands depend only on state and registers, plus imm16 while waiting.
    always_comb begin
        adder_a_o = pc_q;
        adder_b_o = PC_STEP;
        if (state_q == PC_WAIT) begin
            adder_a_o = pc_plus4_q;
            adder_b_o = branch_offset(imm16_i);
        end
    end

    // Next-PC selection; unused encodings fall back to sequential.
    always_comb begin
        target_d = pc_plus4_q;
        case (npc_sel_i)
            NPC_SEL_BRANCH: target_d = branch_taken_i ? adder_r_i : pc_plus4_q;
            NPC_SEL_JUMP:   target_d = {pc_plus4_q[XLEN-1:XLEN-4], jidx_i, 2'b00};
            NPC_SEL_JR:     target_d = rs_val_i & ~XLEN'(3);
            NPC_SEL_ERET:   target_d = epc_q;
            default:        target_d = pc_plus4_q;
        endcase
    end

    // Exceptions take priority over every other event in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= PC_IDLE;
            pc_q        <= RESET_PC;
            pc_plus4_q  <= '0;
            epc_q       <= '0;
            npc_ready_q <= 1'b0;
        end else if (exc_req_i) begin
            state_q     <= PC_IDLE;
            epc_q       <= pc_q;
            pc_q        <= EXC_VEC;
            npc_ready_q <= 1'b0;
        end else begin
            case (state_q)
                PC_IDLE: begin
                    if (fetch_done_i) begin
                        state_q <= PC_INC;
                    end
                end
                PC_INC: begin
                    pc_plus4_q  <= adder_r_i;
                    state_q     <= PC_WAIT;
                    npc_ready_q <= 1'b1;
                end
                PC_WAIT: begin
                    if (pc_we_i) begin
                        pc_q        <= target_d;
                        state_q     <= PC_IDLE;
                        npc_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= PC_IDLE;
                    npc_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4_q;
    assign epc_o       = epc_q;
    assign npc_ready_o = npc_ready_q;

endmodule
